// File: rtl/two_bit_comparator.sv
// Registered magnitude comparator: one-cycle latency eq/lt/gt flags with
// per-sample choice of unsigned or two's-complement interpretation.
module two_bit_comparator #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             signed_cmp,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   logic [WIDTH-1:0] a_key;
   logic [WIDTH-1:0] b_key;
   logic             eq_next;
   logic             lt_next;
   logic             gt_next;
   logic             out_valid_reg;
   logic             eq_reg;
   logic             lt_reg;
   logic             gt_reg;

   // Flipping the MSB in signed mode maps two's complement onto an
   // order-preserving unsigned key, so one unsigned compare serves both modes.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_key
         if (gi == WIDTH - 1) begin : g_msb
            assign a_key[gi] = a[gi] ^ signed_cmp;
            assign b_key[gi] = b[gi] ^ signed_cmp;
         end else begin : g_low
            assign a_key[gi] = a[gi];
            assign b_key[gi] = b[gi];
         end
      end
   endgenerate

   always_comb begin
      eq_next = (a_key == b_key);
      lt_next = (a_key <  b_key);
      gt_next = (a_key >  b_key);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         eq_reg        <= 1'b0;
         lt_reg        <= 1'b0;
         gt_reg        <= 1'b0;
      end else begin
         out_valid_reg <= in_valid;
         if (in_valid) begin
            eq_reg <= eq_next;
            lt_reg <= lt_next;
            gt_reg <= gt_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign eq        = eq_reg;
   assign lt        = lt_reg;
   assign gt        = gt_reg;

endmodule

// File: tb/tb_two_bit_comparator.sv
// Self-checking bench for two_bit_comparator: directed plan items plus
// randomized traffic against an integer-arithmetic reference model.
module tb_two_bit_comparator;

   localparam int W = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         signed_cmp;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         eq;
   logic         lt;
   logic         gt;

   int errors = 0;
   int checks = 0;

   logic m_valid = 1'b0;
   logic m_eq    = 1'b0;
   logic m_lt    = 1'b0;
   logic m_gt    = 1'b0;

   always #5 clk = ~clk;

   two_bit_comparator #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .signed_cmp (signed_cmp),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .eq         (eq),
      .lt         (lt),
      .gt         (gt)
   );

   // Reference: operand value as a plain integer, MSB weighted -2^(W-1) when signed.
   function automatic int value_of(input logic s, input logic [W-1:0] x);
      int v;
      v = int'(x);
      if (s && x[W-1]) v = v - (1 << W);
      return v;
   endfunction

   function automatic logic [2:0] ref_cmp(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
      int xv;
      int yv;
      xv = value_of(s, x);
      yv = value_of(s, y);
      return {xv == yv, xv < yv, xv > yv};
   endfunction

   task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic s,
                       input logic [W-1:0] aa, input logic [W-1:0] bb, input string tag);
      rst        = r;
      in_valid   = v;
      signed_cmp = s;
      a          = aa;
      b          = bb;
      @(posedge clk);
      if (r) begin
         m_valid = 1'b0;
         {m_eq, m_lt, m_gt} = 3'b000;
      end else begin
         m_valid = v;
         if (v) {m_eq, m_lt, m_gt} = ref_cmp(s, aa, bb);
      end
      #1;
      $display("txn %-12s rst=%0b vld=%0b sgn=%0b a=%b b=%b -> ov=%0b eq=%0b lt=%0b gt=%0b",
               tag, r, v, s, aa, bb, out_valid, eq, lt, gt);
      check(tag, {out_valid, eq, lt, gt}, {m_valid, m_eq, m_lt, m_gt});
      if (m_valid)
         check({tag, "_onehot"}, 4'($countones({eq, lt, gt})), 4'd1);
   endtask

   // Directed expectation written straight from the plan, independent of the model.
   task automatic expect_flags(input string tag, input logic ov, input logic [2:0] flags);
      check({tag, "_plan"}, {out_valid, eq, lt, gt}, {ov, flags});
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; signed_cmp = 1'b0; a = '0; b = '0;

      step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, "reset");
      expect_flags("reset", 1'b0, 3'b000);

      // Exhaustive unsigned sweep, b outer, a inner.
      for (int bi = 0; bi < 4; bi++) begin
         for (int ai = 0; ai < 4; ai++) begin
            step(1'b0, 1'b1, 1'b0, 2'(ai), 2'(bi), "u_sweep");
            expect_flags("u_sweep", 1'b1, (ai == bi) ? 3'b100 : (ai < bi) ? 3'b010 : 3'b001);
         end
      end

      step(1'b0, 1'b1, 1'b1, 2'b11, 2'b01, "s_m1_1");   expect_flags("s_m1_1", 1'b1, 3'b010);
      step(1'b0, 1'b1, 1'b1, 2'b10, 2'b11, "s_m2_m1");  expect_flags("s_m2_m1", 1'b1, 3'b010);
      step(1'b0, 1'b1, 1'b1, 2'b01, 2'b10, "s_1_m2");   expect_flags("s_1_m2", 1'b1, 3'b001);
      step(1'b0, 1'b1, 1'b1, 2'b11, 2'b11, "s_eq");     expect_flags("s_eq", 1'b1, 3'b100);
      step(1'b0, 1'b1, 1'b0, 2'b10, 2'b01, "mode_u");   expect_flags("mode_u", 1'b1, 3'b001);
      step(1'b0, 1'b1, 1'b1, 2'b10, 2'b01, "mode_s");   expect_flags("mode_s", 1'b1, 3'b010);

      // Hold: results stay while in_valid is low.
      step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, "hold_load"); expect_flags("hold_load", 1'b1, 3'b001);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 2'b00, 2'b11, "hold");
         expect_flags("hold", 1'b0, 3'b001);
      end

      // Reset overrides a valid sample, then first post-reset sample wins.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, 2'b01, 2'b00, "rst_mid");
         expect_flags("rst_mid", 1'b0, 3'b000);
      end
      step(1'b0, 1'b1, 1'b0, 2'b01, 2'b00, "post_rst"); expect_flags("post_rst", 1'b1, 3'b001);

      // Back-to-back alternation.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            step(1'b0, 1'b1, 1'b0, 2'b00, 2'b11, "alt");
            expect_flags("alt", 1'b1, 3'b010);
         end else begin
            step(1'b0, 1'b1, 1'b0, 2'b11, 2'b00, "alt");
            expect_flags("alt", 1'b1, 3'b001);
         end
      end

      // Randomized traffic with occasional idles and resets.
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
              W'($urandom), W'($urandom), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/two_bit_comparator.md
Name: two_bit_comparator

Overview:
- Registered magnitude comparator for two 2-bit operands; produces mutually exclusive equal / less-than / greater-than flags.
- Used as a leaf compare stage in datapath control logic where a one-cycle registered result is acceptable.
- Operand width is parameterised; default 2 is the production configuration.
- Optional two's-complement compare is selectable per sample.

Parameters:
- WIDTH, 2, operand width in bits (legal range 1..32).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  qualifies a, b and signed_cmp for capture this cycle.
- signed_cmp  input  1  0 = unsigned compare; 1 = two's-complement compare.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  high for one cycle when eq/lt/gt hold a new result.
- eq  output  1  registered A == B.
- lt  output  1  registered A < B.
- gt  output  1  registered A > B.

Behaviour:
- Fixed latency of 1 cycle.
  - Sample on rising clk with in_valid=1 -> eq/lt/gt updated and out_valid=1 at that same edge.
  - Results are visible in the following cycle.
- out_valid is a registered copy of in_valid.
  - No backpressure; one result per cycle is sustainable.
- When in_valid=0:
  - eq/lt/gt hold their last values.
  - out_valid=0 on the next edge.
- Unsigned mode (signed_cmp=0): a and b are compared as unsigned 0..2^WIDTH-1.
- Signed mode (signed_cmp=1): a and b are compared as two's complement (WIDTH=2: -2..1), i.e. the MSB carries negative weight.
- Exactly one of eq/lt/gt is 1 after any captured sample; never two at once.
- Reset (rst=1 at a rising edge):
  - eq=0, lt=0, gt=0, out_valid=0.
  - Reset overrides in_valid in the same cycle.
  - A sample presented during reset is discarded.
- Reset mid-stream: the first result after reset deasserts comes from the first in_valid sample taken while rst=0.
- Outputs are all-zero only after reset, before the first capture.
- Compare logic is purely combinational ahead of the output flops; no internal state beyond the four output registers.
- Inputs X/Z are not required to be handled; they must not be applied when in_valid=1.

Test Plan:
- Exhaustive unsigned sweep, in_valid=1, signed_cmp=0, b outer loop 00..11, a inner loop 00..11, one pair per cycle -> each result one cycle later.
  - eq=1 for (00,00), (01,01), (10,10), (11,11).
  - gt=1 when a>b, e.g. a=11,b=01 -> gt.
  - lt=1 when a<b, e.g. a=01,b=10 -> lt.
  - out_valid=1 throughout.
- Signed checks, signed_cmp=1:
  - a=11,b=01 -> lt=1 (-1<1).
  - a=10,b=11 -> lt=1 (-2<-1).
  - a=01,b=10 -> gt=1.
  - a=11,b=11 -> eq=1.
- Same operands, opposite modes: a=10,b=01 gives gt=1 unsigned and lt=1 signed.
- Hold: apply a=11,b=00 with in_valid=1, then in_valid=0 with a=00,b=11 for 3 cycles -> gt stays 1 and out_valid=0 for those 3 cycles.
- Reset: assert rst for 2 cycles while in_valid=1, a=01, b=00 -> eq=lt=gt=0 and out_valid=0 during reset. Deassert -> gt=1, out_valid=1 one cycle after the first non-reset edge.
- Back-to-back alternation a=00,b=11 then a=11,b=00 every cycle -> outputs toggle lt/gt each cycle, never overlapping, out_valid continuously 1.
